int_req_ctrl: RTL and testbench

Interrupt request controller that drives the `interrupter` input of the `mips` core. It:
- synchronizes up to four external interrupt sources and edge-detects them;
- latches the edges as pending, applies a software mask and picks the highest-priority request;
- holds `interrupter` asserted until the core acknowledges trap entry, then blocks new requests until the core signals return from the handler.

---
 rtl/int_req_if.sv | 27 ++
 rtl/int_req_ctrl.sv | 111 +++++++++++
 tb/tb_int_req_ctrl.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/int_req_if.sv
// rtl/int_req_if.sv - interrupt request controller bus interface
// The core/system side uses master; the controller uses slave.
interface int_req_if #(
   parameter int NUM_SRC = 4
);
   logic [NUM_SRC-1:0] src_in;
   logic               mask_we;
   logic [NUM_SRC-1:0] mask_wdata;
   logic               int_ack;
   logic               int_ret;
   logic               interrupter;
   logic [2:0]         int_id;
   logic [31:0]        int_vector;
   logic [NUM_SRC-1:0] pending;
   logic [NUM_SRC-1:0] mask;
   logic               busy;

   modport master (
      output src_in, mask_we, mask_wdata, int_ack, int_ret,
      input  interrupter, int_id, int_vector, pending, mask, busy
   );

   modport slave (
      input  src_in, mask_we, mask_wdata, int_ack, int_ret,
      output interrupter, int_id, int_vector, pending, mask, busy
   );
endinterface

// File: rtl/int_req_ctrl.sv
// rtl/int_req_ctrl.sv - interrupt request controller for the mips core
// Synchronizes and edge-detects sources, latches pending, masks, arbitrates and holds one request.
module int_req_ctrl #(
   parameter int          NUM_SRC    = 4,
   parameter logic [31:0] VEC_BASE   = 32'h0000_0100,
   parameter logic [31:0] VEC_STRIDE = 32'h0000_0010
) (
   input logic     clk,
   input logic     rst,
   int_req_if.slave bus
);
   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_REQ     = 2'd1,
      S_SERVICE = 2'd2
   } state_t;

   localparam logic [NUM_SRC-1:0] L_ONE = NUM_SRC'(1);

   state_t             r_state;
   state_t             w_state_nxt;
   logic [NUM_SRC-1:0] r_s1;
   logic [NUM_SRC-1:0] r_s2;
   logic [NUM_SRC-1:0] r_s3;
   logic [NUM_SRC-1:0] r_pending;
   logic [NUM_SRC-1:0] r_mask;
   logic [2:0]         r_int_id;
   logic               r_interrupter;

   logic [NUM_SRC-1:0] w_edge;
   logic [NUM_SRC-1:0] w_req;
   logic [NUM_SRC-1:0] w_clr;
   logic [NUM_SRC-1:0] w_pending_nxt;
   logic [2:0]         w_sel_id;
   logic               w_commit;

   assign w_edge = r_s2 & ~r_s3;
   assign w_req  = r_pending & r_mask;

   // Descending scan so the lowest requesting index wins.
   always_comb begin
      w_sel_id = 3'd0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (w_req[i]) begin
            w_sel_id = 3'(i);
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_commit    = 1'b0;
      w_clr       = '0;
      case (r_state)
         S_IDLE: begin
            if (|w_req) begin
               w_commit    = 1'b1;
               w_state_nxt = S_REQ;
            end
         end
         S_REQ: begin
            if (bus.int_ack) begin
               w_clr       = L_ONE << r_int_id;
               w_state_nxt = S_SERVICE;
            end
         end
         S_SERVICE: begin
            if (bus.int_ret) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // A new edge overrides the ack clear on the same bit.
   assign w_pending_nxt = (r_pending & ~w_clr) | w_edge;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= S_IDLE;
         r_s1          <= '0;
         r_s2          <= '0;
         r_s3          <= '0;
         r_pending     <= '0;
         r_mask        <= '1;
         r_int_id      <= 3'd0;
         r_interrupter <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_s1          <= bus.src_in;
         r_s2          <= r_s1;
         r_s3          <= r_s2;
         r_pending     <= w_pending_nxt;
         r_interrupter <= (w_state_nxt == S_REQ);
         if (bus.mask_we) begin
            r_mask <= bus.mask_wdata;
         end
         if (w_commit) begin
            r_int_id <= w_sel_id;
         end
      end
   end

   assign bus.interrupter = r_interrupter;
   assign bus.int_id      = r_int_id;
   assign bus.int_vector  = VEC_BASE + (32'(r_int_id) * VEC_STRIDE);
   assign bus.pending     = r_pending;
   assign bus.mask        = r_mask;
   assign bus.busy        = (r_state != S_IDLE);
endmodule

// File: tb/tb_int_req_ctrl.sv
// tb/tb_int_req_ctrl.sv - self-checking bench for int_req_ctrl
module tb_int_req_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_pass  = 0;
   int   n_total = 0;

   int_req_if #(.NUM_SRC(4)) bus ();

   int_req_ctrl #(
      .NUM_SRC   (4),
      .VEC_BASE  (32'h0000_0100),
      .VEC_STRIDE(32'h0000_0010)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #10 clk = ~clk;

   typedef struct {
      logic [3:0] src;
      logic       mwe;
      logic [3:0] mwd;
      logic       ack;
      logic       ret;
      logic       e_irq;
      logic       e_busy;
      logic [2:0] e_id;
      logic [3:0] e_pend;
      logic [3:0] e_mask;
   } vec_t;

   vec_t tbl[19];

   // Reference model state
   logic [3:0] m_h0, m_h1, m_h2;
   logic [3:0] m_pend, m_mask;
   logic       m_req, m_svc;
   logic [2:0] m_id;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic chk_all(input string name, input logic irq, input logic busy,
                          input logic [2:0] id, input logic [3:0] pend, input logic [3:0] msk);
      chk({name, " irq"},  32'(bus.interrupter), 32'(irq));
      chk({name, " busy"}, 32'(bus.busy),        32'(busy));
      chk({name, " id"},   32'(bus.int_id),      32'(id));
      chk({name, " vec"},  bus.int_vector,       32'h100 + 32'(id) * 32'h10);
      chk({name, " pend"}, 32'(bus.pending),     32'(pend));
      chk({name, " mask"}, 32'(bus.mask),        32'(msk));
   endtask

   task automatic wait_irq(input string name, input int budget);
      int n = 0;
      while (bus.interrupter !== 1'b1 && n < budget) begin
         tick();
         n++;
      end
      chk({name, " irq rise"}, 32'(bus.interrupter), 32'd1);
   endtask

   task automatic drive(input logic [3:0] src, input logic mwe, input logic [3:0] mwd,
                        input logic ack, input logic ret);
      bus.src_in     = src;
      bus.mask_we    = mwe;
      bus.mask_wdata = mwd;
      bus.int_ack    = ack;
      bus.int_ret    = ret;
   endtask

   task automatic do_reset();
      drive(4'b0, 1'b0, 4'b0, 1'b0, 1'b0);
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   function automatic vec_t mk(input logic [3:0] src, input logic mwe, input logic [3:0] mwd,
                               input logic ack, input logic ret, input logic irq, input logic busy,
                               input logic [2:0] id, input logic [3:0] pend, input logic [3:0] msk);
      vec_t v;
      v.src = src; v.mwe = mwe; v.mwd = mwd; v.ack = ack; v.ret = ret;
      v.e_irq = irq; v.e_busy = busy; v.e_id = id; v.e_pend = pend; v.e_mask = msk;
      return v;
   endfunction

   // Behavioural reference: rising sample seen two edges later sets pending; one request at a time.
   task automatic model_step(input logic [3:0] src, input logic mwe, input logic [3:0] mwd,
                             input logic ack, input logic ret);
      logic [3:0] rise, clr, act, low;
      rise = m_h1 & ~m_h2;
      clr  = 4'b0;
      act  = m_pend & m_mask;
      if (!m_req && !m_svc) begin
         if (act != 4'b0) begin
            low   = act & (~act + 4'd1);
            m_id  = 3'($clog2(low));
            m_req = 1'b1;
         end
      end else if (m_req) begin
         if (ack) begin
            clr[m_id] = 1'b1;
            m_req     = 1'b0;
            m_svc     = 1'b1;
         end
      end else if (ret) begin
         m_svc = 1'b0;
      end
      m_pend = (m_pend & ~clr) | rise;
      if (mwe) m_mask = mwd;
      m_h2 = m_h1;
      m_h1 = m_h0;
      m_h0 = src;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [3:0] r_src, r_mwd;
      logic       r_mwe, r_ack, r_ret;

      // single request, ignored strobes, masking
      tbl[0]  = mk(4'b0100, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 4'b0000, 4'b1111);
      tbl[1]  = mk(4'b0100, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 4'b0000, 4'b1111);
      tbl[2]  = mk(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 4'b0100, 4'b1111);
      tbl[3]  = mk(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b1, 3'd2, 4'b0100, 4'b1111);
      tbl[4]  = mk(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b1, 3'd2, 4'b0100, 4'b1111);
      tbl[5]  = mk(4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1, 3'd2, 4'b0000, 4'b1111);
      tbl[6]  = mk(4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1, 3'd2, 4'b0000, 4'b1111);
      tbl[7]  = mk(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 3'd2, 4'b0000, 4'b1111);
      tbl[8]  = mk(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 3'd2, 4'b0000, 4'b1111);
      tbl[9]  = mk(4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 3'd2, 4'b0000, 4'b1111);
      tbl[10] = mk(4'b0000, 1'b1, 4'b1110, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 4'b0000, 4'b1110);
      tbl[11] = mk(4'b0001, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 4'b0000, 4'b1110);
      tbl[12] = mk(4'b0001, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 4'b0000, 4'b1110);
      tbl[13] = mk(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 4'b0001, 4'b1110);
      tbl[14] = mk(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 4'b0001, 4'b1110);
      tbl[15] = mk(4'b0000, 1'b1, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 4'b0001, 4'b1111);
      tbl[16] = mk(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 4'b0001, 4'b1111);
      tbl[17] = mk(4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 4'b0000, 4'b1111);
      tbl[18] = mk(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 4'b0000, 4'b1111);

      drive(4'b0, 1'b0, 4'b0, 1'b0, 1'b0);
      tick();
      chk_all("reset", 1'b0, 1'b0, 3'd0, 4'b0000, 4'b1111);
      do_reset();
      tick();

      for (int r = 0; r < 19; r++) begin
         drive(tbl[r].src, tbl[r].mwe, tbl[r].mwd, tbl[r].ack, tbl[r].ret);
         tick();
         chk_all($sformatf("tbl%0d", r), tbl[r].e_irq, tbl[r].e_busy, tbl[r].e_id,
                 tbl[r].e_pend, tbl[r].e_mask);
      end
      drive(4'b0, 1'b0, 4'b0, 1'b0, 1'b0);
      tick();

      // priority: sources 3 and 1 together
      bus.src_in = 4'b1010; tick(); tick(); bus.src_in = 4'b0;
      wait_irq("prio", 10);
      chk("prio id", 32'(bus.int_id), 32'd1);
      chk("prio pend", 32'(bus.pending), 32'b1010);
      bus.int_ack = 1'b1; tick(); bus.int_ack = 1'b0;
      chk("prio ack irq", 32'(bus.interrupter), 32'd0);
      bus.int_ret = 1'b1; tick(); bus.int_ret = 1'b0;
      chk("prio ret busy", 32'(bus.busy), 32'd0);
      tick();
      chk("prio second irq", 32'(bus.interrupter), 32'd1);
      chk("prio second id", 32'(bus.int_id), 32'd3);
      chk("prio second vec", bus.int_vector, 32'h130);
      bus.int_ack = 1'b1; tick(); bus.int_ack = 1'b0;
      bus.int_ret = 1'b1; tick(); bus.int_ret = 1'b0;
      tick();
      chk("prio done pend", 32'(bus.pending), 32'd0);

      // set-vs-clear race on source 2
      bus.src_in = 4'b0100; tick(); tick(); bus.src_in = 4'b0;
      wait_irq("race", 10);
      chk("race id", 32'(bus.int_id), 32'd2);
      bus.src_in = 4'b0100; tick(); tick();
      bus.src_in = 4'b0; bus.int_ack = 1'b1; tick(); bus.int_ack = 1'b0;
      chk("race irq", 32'(bus.interrupter), 32'd0);
      chk("race busy", 32'(bus.busy), 32'd1);
      chk("race pend kept", 32'(bus.pending), 32'b0100);
      bus.int_ret = 1'b1; tick(); bus.int_ret = 1'b0;
      tick();
      chk("race reissue irq", 32'(bus.interrupter), 32'd1);
      chk("race reissue id", 32'(bus.int_id), 32'd2);
      bus.int_ack = 1'b1; tick(); bus.int_ack = 1'b0;
      bus.int_ret = 1'b1; tick(); bus.int_ret = 1'b0;
      tick();
      chk("race done pend", 32'(bus.pending), 32'd0);

      // two pulses on source 0 while in SERVICE collapse into one pending bit
      bus.src_in = 4'b0001; tick(); tick(); bus.src_in = 4'b0;
      wait_irq("dbl", 10);
      bus.int_ack = 1'b1; tick(); bus.int_ack = 1'b0;
      bus.src_in = 4'b0001; tick(); tick();
      bus.src_in = 4'b0000; tick(); tick();
      bus.src_in = 4'b0001; tick(); tick();
      bus.src_in = 4'b0000;
      for (int i = 0; i < 4; i++) tick();
      chk("dbl pend", 32'(bus.pending), 32'b0001);
      chk("dbl busy", 32'(bus.busy), 32'd1);
      chk("dbl irq", 32'(bus.interrupter), 32'd0);
      bus.int_ret = 1'b1; tick(); bus.int_ret = 1'b0;
      tick();
      chk("dbl req irq", 32'(bus.interrupter), 32'd1);
      chk("dbl req id", 32'(bus.int_id), 32'd0);
      bus.int_ack = 1'b1; tick(); bus.int_ack = 1'b0;
      bus.int_ret = 1'b1; tick(); bus.int_ret = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      chk_all("dbl done", 1'b0, 1'b0, 3'd0, 4'b0000, 4'b1111);

      // asynchronous reset in REQ, source 1 held high across release
      bus.src_in = 4'b1000; tick(); tick(); bus.src_in = 4'b0;
      wait_irq("arst pre", 10);
      chk("arst pre id", 32'(bus.int_id), 32'd3);
      #3;
      rst = 1'b1;
      bus.src_in = 4'b0010;
      #1;
      chk_all("arst", 1'b0, 1'b0, 3'd0, 4'b0000, 4'b1111);
      tick();
      rst = 1'b0;
      wait_irq("arst held src", 10);
      chk("arst held id", 32'(bus.int_id), 32'd1);
      bus.src_in = 4'b0;
      bus.int_ack = 1'b1; tick(); bus.int_ack = 1'b0;
      bus.int_ret = 1'b1; tick(); bus.int_ret = 1'b0;

      // randomized run against the reference model
      do_reset();
      m_h0 = 4'b0; m_h1 = 4'b0; m_h2 = 4'b0;
      m_pend = 4'b0; m_mask = 4'b1111;
      m_req = 1'b0; m_svc = 1'b0; m_id = 3'd0;
      r_src = 4'b0;
      for (int c = 0; c < 1500; c++) begin
         for (int b = 0; b < 4; b++) begin
            if ($urandom_range(0, 5) == 0) r_src[b] = ~r_src[b];
         end
         r_mwe = ($urandom_range(0, 7) == 0);
         r_mwd = 4'($urandom_range(0, 15)) | 4'($urandom_range(0, 15));
         r_ack = ($urandom_range(0, 3) == 0);
         r_ret = ($urandom_range(0, 3) == 0);
         drive(r_src, r_mwe, r_mwd, r_ack, r_ret);
         tick();
         model_step(r_src, r_mwe, r_mwd, r_ack, r_ret);
         chk_all($sformatf("rnd%0d", c), m_req, m_req | m_svc, m_id, m_pend, m_mask);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
